mem_responder: RTL and testbench
================================

# mem_responder

Synthesizable memory-side responder for the RV32I core's data/instruction memory port. It accepts single-word read and write requests from the CPU and services them from an internal word array, applying byte write masks. Completion is signalled with a one-cycle `mem_resp` after a fixed, parameterized latency. It also provides a backdoor load port for program preload and free-running transaction counters for performance checks.

## Interface
- `ADDR_BITS`, 10: number of word-index bits; the array holds 2^ADDR_BITS 32-bit words.
- `LATENCY`, 3: cycles from request acceptance to `mem_resp`; legal range is 1..15.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  read request; held by the CPU until `mem_resp`.
- `mem_write`  in  1  write request; held by the CPU until `mem_resp`.
- `mem_wmask`  in  4  byte enables; bit i enables byte lane i (bits [8i+7:8i]).
- `mem_address`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_rdata`  out  32  read data; valid in the `mem_resp` cycle of a read.
- `mem_resp`  out  1  one-cycle completion pulse.
- `load_en`  in  1  backdoor full-word write enable.
- `load_addr`  in  ADDR_BITS  backdoor word index.
- `load_data`  in  32  backdoor data.
- `read_count`  out  32  completed reads, wrapping.
- `write_count`  out  32  completed writes, wrapping.

## Operation
- Word index is `mem_address[ADDR_BITS+1:2]`.
  - Bits [1:0] are ignored; the CPU aligns addresses.
  - Bits above ADDR_BITS+1 are ignored, so addresses alias.
- FSM states:
  - IDLE:
    - If `mem_read` or `mem_write` is high, capture the word index, `mem_wdata`, `mem_wmask`, and the operation type.
    - Load the latency counter with LATENCY-1.
    - Go to WAIT.
  - WAIT:
    - If the counter is 0, go to RESP; otherwise decrement it.
  - RESP:
    - Assert `mem_resp`.
    - For a read, drive `mem_rdata` from the array at the captured index.
    - For a write, commit masked bytes at the captured index; `mem_rdata` holds its prior value.
    - Increment the matching counter.
    - Go to IDLE.
- `mem_read` and `mem_write` both high is treated as a write.
- A write with `mem_wmask` = 0 still completes and counts, but changes no bytes.
- Request inputs are sampled only in IDLE.
  - Changes or deassertion during WAIT/RESP are ignored; captured values are used.
- Backdoor write: when `load_en` is high, `load_data` is written at `load_addr` in that cycle, in any state.
  - If it coincides with a RESP-cycle CPU write to the same word, apply the backdoor write first, then overlay the CPU's masked bytes.
  - A RESP-cycle read of a word being backdoor-written in the same cycle returns the pre-write contents.
- Counters wrap from 0xFFFF_FFFF to 0.
- Reset values:
  - FSM in IDLE.
  - `mem_resp` = 0, `mem_rdata` = 0.
  - `read_count` = 0, `write_count` = 0.
  - Latency counter = 0.
  - Array contents are not cleared.
- Reset mid-transaction: FSM returns to IDLE, the pending write is dropped, and no `mem_resp` is issued.

## Timing
- With the request first high in IDLE at cycle 0, `mem_resp` is high exactly in cycle LATENCY+1.
  - The cycle-0 edge enters WAIT.
  - The FSM spends LATENCY cycles in WAIT, then one cycle in RESP.
- `mem_resp` is high for exactly one cycle per accepted request and is never high outside RESP.
- `mem_rdata` is registered and holds its value until the next read's RESP.
- Back-to-back requests:
  - The CPU may present a new request in the cycle after RESP; it is accepted in IDLE that cycle.
  - Minimum spacing between `mem_resp` pulses is LATENCY+2 cycles.
- Write data becomes visible to a read accepted in any later cycle.

## Test plan
- Reset, then a read of address 0x0000_0010 after a backdoor load of index 4 with 0xDEAD_BEEF:
  - With LATENCY=3, `mem_resp` pulses in cycle 4 with `mem_rdata`=0xDEAD_BEEF.
  - `read_count`=1.
- Byte-masked write:
  - Preload 0x1122_3344 at index 8, then write 0xAABB_CCDD to 0x20 with mask 4'b0101.
  - A subsequent read returns 0x11BB_33DD; `write_count`=1.
- Back-to-back traffic: write 0x5 to 0x40, then immediately read 0x40 the cycle after `mem_resp`.
  - Read returns 0x0000_0005.
  - Resp pulses are 5 cycles apart.
- Aliasing with ADDR_BITS=10: write 0xCAFE_F00D to 0x0000_1004, then read 0x0000_0004.
  - Read returns 0xCAFE_F00D.
- Reset asserted in WAIT of a write of 0xFFFF_FFFF to 0x8 (prior contents 0x0):
  - No `mem_resp` is issued; counters read 0.
  - A later read of 0x8 returns 0x0.
- Simultaneous read and write with LATENCY=1:
  - Treated as a write; `mem_resp` pulses in cycle 2.
  - `write_count` increments, `read_count` is unchanged, and `mem_rdata` is unchanged.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the RV32I core's memory port. Services single-word
//   read/write requests from an internal word array with byte write masks and
//   answers each accepted request with a one-cycle mem_resp after LATENCY
//   cycles in WAIT. A backdoor port preloads words; two free-running counters
//   count completed reads and writes.
//
// Parameters
//   ADDR_BITS  word-index width; array holds 2^ADDR_BITS 32-bit words
//   LATENCY    cycles spent in WAIT before the response cycle (1..15)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mem_read, mem_write      request strobes, held by the CPU until mem_resp
//   mem_wmask                byte-lane write enables
//   mem_address, mem_wdata   byte address (word index = [ADDR_BITS+1:2]), data
//   mem_rdata, mem_resp      registered read data, one-cycle completion pulse
//   load_en/addr/data        backdoor full-word write, honoured in any state
//   read_count, write_count  completed transaction counters, wrapping
module mem_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [3:0]           mem_wmask,
  input  logic [31:0]          mem_address,
  input  logic [31:0]          mem_wdata,
  output logic [31:0]          mem_rdata,
  output logic                 mem_resp,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [31:0]          load_data,
  output logic [31:0]          read_count,
  output logic [31:0]          write_count
);

  localparam int unsigned DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state, state_next;

  logic [3:0]           lat_cnt;
  logic [ADDR_BITS-1:0] req_idx;
  logic [31:0]          req_wdata;
  logic [3:0]           req_wmask;
  logic                 req_is_write;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        enter_resp;
  logic        commit;
  logic [31:0] merged_word;

  // Address bits outside the word index are deliberately ignored (alignment
  // and aliasing); fold them into a sink so they are not flagged as unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_address[31:ADDR_BITS+2], mem_address[1:0]};

  assign accept     = (state == ST_IDLE) && (mem_read || mem_write);
  assign enter_resp = (state == ST_WAIT) && (lat_cnt == '0);
  assign commit     = (state == ST_RESP) && req_is_write && !rst;

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (mem_read || mem_write) state_next = ST_WAIT;
      ST_WAIT: if (lat_cnt == '0)         state_next = ST_RESP;
      ST_RESP:                            state_next = ST_IDLE;
      default:                            state_next = ST_IDLE;
    endcase
  end

  // State, latency counter, response outputs and counters.
  // mem_resp and mem_rdata are loaded on the edge entering RESP so they are
  // registered yet valid during the RESP cycle itself; a backdoor write in the
  // RESP cycle therefore cannot disturb the returned word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      lat_cnt     <= '0;
      mem_resp    <= 1'b0;
      mem_rdata   <= '0;
      read_count  <= '0;
      write_count <= '0;
    end else begin
      state    <= state_next;
      mem_resp <= enter_resp;

      if (accept) begin
        lat_cnt <= LAT_INIT;
      end else if ((state == ST_WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 4'd1;
      end

      if (enter_resp && !req_is_write) begin
        mem_rdata <= mem[req_idx];
      end

      if (state == ST_RESP) begin
        if (req_is_write) write_count <= write_count + 32'd1;
        else              read_count  <= read_count + 32'd1;
      end
    end
  end

  // Request capture; only meaningful once accepted, so no reset needed.
  // A simultaneous read and write is captured as a write.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_idx      <= mem_address[ADDR_BITS+1:2];
      req_wdata    <= mem_wdata;
      req_wmask    <= mem_wmask;
      req_is_write <= mem_write;
    end
  end

  // The CPU's masked bytes are merged over the backdoor word when both target
  // the same index in the RESP cycle, so the backdoor lands first and the CPU
  // overlays it.
  always_comb begin
    merged_word = (load_en && (load_addr == req_idx)) ? load_data : mem[req_idx];
    for (int unsigned i = 0; i < 4; i++) begin
      if (req_wmask[i]) merged_word[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  // Word array; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (commit)  mem[req_idx]   <= merged_word;
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int AB  = 10;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_read = 1'b0, mem_write = 1'b0;
  logic [3:0]    mem_wmask = '0;
  logic [31:0]   mem_address = '0, mem_wdata = '0;
  logic [31:0]   mem_rdata;
  logic          mem_resp;
  logic          load_en = 1'b0;
  logic [AB-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
  logic [31:0]   read_count, write_count;

  // Second instance with LATENCY=1 for the simultaneous read/write case.
  logic          rst1 = 1'b1;
  logic          rd1 = 1'b0, wr1 = 1'b0;
  logic [3:0]    wmask1 = '0;
  logic [31:0]   addr1 = '0, wdata1 = '0;
  logic [31:0]   rdata1;
  logic          resp1;
  logic          le1 = 1'b0;
  logic [AB-1:0] la1 = '0;
  logic [31:0]   ld1 = '0;
  logic [31:0]   rc1, wc1;

  mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data),
    .read_count(read_count), .write_count(write_count));

  mem_responder #(.ADDR_BITS(AB), .LATENCY(1)) u_dut_lat1 (
    .clk(clk), .rst(rst1), .mem_read(rd1), .mem_write(wr1),
    .mem_wmask(wmask1), .mem_address(addr1), .mem_wdata(wdata1),
    .mem_rdata(rdata1), .mem_resp(resp1), .load_en(le1),
    .load_addr(la1), .load_data(ld1),
    .read_count(rc1), .write_count(wc1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain word array plus expected counters/read data.
  logic [31:0] model_mem [1 << AB];
  logic [31:0] exp_reads = '0, exp_writes = '0, exp_rdata = '0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic backdoor(input logic [AB-1:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    model_mem[a] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge of the
  // cycle after the response. bd_mode: 0 none, 1 backdoor to the same word
  // during the response cycle, 2 backdoor to a random word then.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask,
                         input int bd_mode, output int resp_cyc);
    logic [AB-1:0] idx;
    logic [AB-1:0] la;
    logic [31:0]   w;
    int            k;
    bit            got;
    idx = addr[AB+1:2];
    mem_read = rd; mem_write = wr; mem_address = addr;
    mem_wdata = wdata; mem_wmask = mask;
    k = 0; got = 0;
    while (!got && k < LAT + 6) begin
      @(negedge clk);
      k++;
      if (mem_resp) got = 1;
      else begin
        // Inputs outside IDLE must be ignored.
        mem_read = 1'($urandom); mem_write = 1'($urandom);
        mem_address = $urandom; mem_wdata = $urandom; mem_wmask = 4'($urandom);
      end
    end
    resp_cyc = cyc;
    check("resp_cycle", k, LAT + 1);
    if (rd && !wr) exp_rdata = model_mem[idx];
    check(wr ? "rdata_hold_on_write" : "rdata", mem_rdata, exp_rdata);
    mem_read = 1'b0; mem_write = 1'b0;
    if (bd_mode != 0) begin
      la = (bd_mode == 1) ? idx : AB'($urandom);
      load_en = 1'b1; load_addr = la; load_data = $urandom;
      model_mem[la] = load_data;
    end
    if (wr) begin
      w = model_mem[idx];
      for (int i = 0; i < 4; i++) if (mask[i]) w[8*i +: 8] = wdata[8*i +: 8];
      model_mem[idx] = w;
      exp_writes++;
    end else begin
      exp_reads++;
    end
    @(negedge clk);
    load_en = 1'b0;
    check("resp_one_cycle", {31'b0, mem_resp}, 32'd0);
    check("read_count", read_count, exp_reads);
    check("write_count", write_count, exp_writes);
  endtask

  initial begin
    int rc_a, rc_b, k, pulses;
    bit rd, wr;

    // Reset state.
    @(negedge clk); @(negedge clk);
    check("rst_resp", {31'b0, mem_resp}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_rcount", read_count, 32'd0);
    check("rst_wcount", write_count, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < (1 << AB); i++) backdoor(AB'(i), $urandom);

    // Backdoor load then read; response in cycle 4.
    backdoor(10'd4, 32'hDEAD_BEEF);
    run_txn(1, 0, 32'h0000_0010, '0, '0, 0, rc_a);
    check("tp_read_deadbeef", mem_rdata, 32'hDEAD_BEEF);
    check("tp_rcount1", read_count, 32'd1);

    // Byte-masked write.
    backdoor(10'd8, 32'h1122_3344);
    run_txn(0, 1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 0, rc_a);
    check("tp_wcount1", write_count, 32'd1);
    run_txn(1, 0, 32'h0000_0020, '0, '0, 0, rc_a);
    check("tp_masked", mem_rdata, 32'h11BB_33DD);

    // Back-to-back write then read.
    run_txn(0, 1, 32'h0000_0040, 32'h0000_0005, 4'hF, 0, rc_a);
    run_txn(1, 0, 32'h0000_0040, '0, '0, 0, rc_b);
    check("tp_b2b_data", mem_rdata, 32'h0000_0005);
    check("tp_b2b_spacing", rc_b - rc_a, LAT + 2);

    // Aliasing.
    run_txn(0, 1, 32'h0000_1004, 32'hCAFE_F00D, 4'hF, 0, rc_a);
    run_txn(1, 0, 32'h0000_0004, '0, '0, 0, rc_a);
    check("tp_alias", mem_rdata, 32'hCAFE_F00D);

    // Reset in WAIT drops the write.
    backdoor(10'd2, 32'h0);
    mem_write = 1'b1; mem_address = 32'h8; mem_wdata = 32'hFFFF_FFFF; mem_wmask = 4'hF;
    @(negedge clk); @(negedge clk);
    rst = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_reads = '0; exp_writes = '0; exp_rdata = '0;
    pulses = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      if (mem_resp) pulses++;
      @(negedge clk);
    end
    check("rst_mid_no_resp", pulses, 0);
    check("rst_mid_rcount", read_count, 32'd0);
    check("rst_mid_wcount", write_count, 32'd0);
    run_txn(1, 0, 32'h0000_0008, '0, '0, 0, rc_a);
    check("rst_mid_dropped", mem_rdata, 32'h0);

    // Randomized traffic with gaps, aliasing, zero masks and backdoor collisions.
    for (int n = 0; n < 150; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 1) == 1) backdoor(AB'($urandom), $urandom);
        else @(negedge clk);
      end
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      run_txn(rd, wr, {$urandom_range(0, 3) == 0 ? 20'($urandom) : 20'h0,
                       2'($urandom), 8'($urandom), 2'($urandom)},
              $urandom, 4'($urandom), int'($urandom_range(0, 2)), rc_a);
    end

    // Simultaneous read+write on the LATENCY=1 instance.
    @(negedge clk);
    rst1 = 1'b0;
    le1 = 1'b1; la1 = '0; ld1 = 32'h1234_5678;
    @(negedge clk);
    le1 = 1'b0;
    rd1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0; wdata1 = 32'hA5A5_A5A5; wmask1 = 4'hF;
    k = 0;
    while (k < 8) begin
      @(negedge clk); k++;
      if (resp1) break;
    end
    check("l1_resp_cycle", k, 2);
    check("l1_rdata_unchanged", rdata1, 32'h0);
    rd1 = 1'b0; wr1 = 1'b0;
    @(negedge clk);
    check("l1_wcount", wc1, 32'd1);
    check("l1_rcount", rc1, 32'd0);
    rd1 = 1'b1;
    k = 0;
    while (k < 8) begin
      @(negedge clk); k++;
      if (resp1) break;
    end
    check("l1_read_resp_cycle", k, 2);
    check("l1_read_data", rdata1, 32'hA5A5_A5A5);
    rd1 = 1'b0;
    @(negedge clk);
    check("l1_rcount_after", rc1, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
